// File: rtl/burst_memory.sv
// Single-port word memory with command handshake, burst write/read, byte strobes and read back-pressure.
// Optional per-byte even parity with error reporting is enabled by defining PARITY_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready=1, waiting for a command
// S_WRITE | wready=1, accepting len+1 write beats
// S_READ  | streaming len+1 read beats, honouring rready
// S_DONE  | one-cycle done pulse, err reported alongside

module burst_memory #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  rlast,
    input  logic                  rready,
    output logic                  done,
    output logic                  err
);

    localparam int NB = WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  wready_q, wready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  fetch_pend_q, fetch_pend_d;
    logic                  err_flag_q, err_flag_d;

    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic                  cmd_acc;
    logic                  addr_bad;
    logic                  wr_en;
    logic                  fetch;
    logic                  rd_hs;
    logic [ADDR_WIDTH-1:0] cur_nxt;
    logic [WIDTH-1:0]      rd_word;
    logic                  par_bad;

    assign cmd_acc  = valid && ready_q;
    // Extra MSB keeps the compare meaningful when DEPTH is a power of two.
    assign addr_bad = ({1'b0, addr} >= (ADDR_WIDTH+1)'(DEPTH));
    assign wr_en    = wvalid && wready_q;
    assign rd_hs    = rvalid_q && rready;
    assign fetch    = (state_q == S_READ) && fetch_pend_q && (!rvalid_q || rready);
    assign cur_nxt  = (cur_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : cur_q + 1'b1;
    assign rd_word  = mem_q[cur_q];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem_q[cur_q][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

`ifdef PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] rd_par;

    assign rd_par = par_q[cur_q];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) par_q[cur_q][b] <= ^wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        par_bad = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if ((^rd_word[8*b +: 8]) != rd_par[b]) par_bad = 1'b1;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            wready_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            cur_q        <= '0;
            cnt_q        <= '0;
            fetch_pend_q <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            wready_q     <= wready_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            cur_q        <= cur_d;
            cnt_q        <= cnt_d;
            fetch_pend_q <= fetch_pend_d;
            err_flag_q   <= err_flag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    if (addr_bad)   state_d = S_DONE;
                    else if (wr_rd) state_d = S_WRITE;
                    else            state_d = S_READ;
                end
            end
            S_WRITE: if (wr_en && (cnt_q == '0)) state_d = S_DONE;
            S_READ:  if (rd_hs && rlast_q)       state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered: each *_d reflects the state being entered.
    always_comb begin
        cur_d        = cur_q;
        cnt_d        = cnt_q;
        fetch_pend_d = fetch_pend_q;
        err_flag_d   = err_flag_q;
        rdata_d      = rdata_q;
        rvalid_d     = rvalid_q;
        rlast_d      = rlast_q;

        if (cmd_acc) begin
            cur_d        = addr;
            cnt_d        = len;
            fetch_pend_d = !wr_rd && !addr_bad;
            err_flag_d   = addr_bad;
        end

        if (wr_en) begin
            cur_d = cur_nxt;
            cnt_d = cnt_q - LEN_WIDTH'(1);
        end

        if (rd_hs) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end

        // A completing beat may be replaced by the next one in the same cycle.
        if (fetch) begin
            rdata_d  = rd_word;
            rvalid_d = 1'b1;
            rlast_d  = (cnt_q == '0);
            cur_d    = cur_nxt;
            if (cnt_q == '0) fetch_pend_d = 1'b0;
            else             cnt_d        = cnt_q - LEN_WIDTH'(1);
            if (par_bad)     err_flag_d   = 1'b1;
        end

        ready_d  = (state_d == S_IDLE);
        wready_d = (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_DONE) && err_flag_d;
    end

    assign ready  = ready_q;
    assign wready = wready_q;
    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign rdata  = rdata_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_burst_memory.sv
// Self-checking bench for burst_memory: directed scenarios plus randomized bursts against an array model.
// With PARITY_EN defined the parity-corruption scenario deposits a flipped bit into the array.

module tb_burst_memory;

    localparam int WIDTH = 32;
    localparam int DEPTH = 48;
    localparam int AW    = 6;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          valid = 1'b0;
    logic          ready;
    logic          wr_rd = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [LW-1:0] len = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          rlast;
    logic          rready = 1'b0;
    logic          done;
    logic          err;

    int checks = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] bdata [16];
    logic [3:0]  bstrb [16];
    logic [31:0] rd_got [16];
    logic [31:0] last_rdata;

    burst_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(16)) dut (
        .clk(clk), .res(res), .valid(valid), .ready(ready), .wr_rd(wr_rd),
        .addr(addr), .len(len), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
        .wready(wready), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
        .rready(rready), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input int a, input int l, output bit ok);
        bit acc = 0;
        valid = 1'b1;
        wr_rd = w;
        addr  = AW'(a);
        len   = LW'(l);
        for (int c = 0; c < 20 && !acc; c++) begin
            if (ready) acc = 1;
            @(negedge clk);
        end
        valid = 1'b0;
        addr  = AW'($urandom);
        len   = LW'($urandom);
        ok = acc;
        if (!acc) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic write_burst(input int a, input int l);
        bit ok;
        int i = 0;
        int cyc = 0;
        send_cmd(1'b1, a, l, ok);
        if (ok) begin
            while (i <= l && cyc < 200) begin
                wvalid = ($urandom_range(0, 3) != 0);
                wdata  = bdata[i];
                wstrb  = bstrb[i];
                if (wvalid && wready) begin
                    for (int b = 0; b < 4; b++)
                        if (bstrb[i][b]) model[(a + i) % DEPTH][8*b +: 8] = bdata[i][8*b +: 8];
                    i++;
                end
                @(negedge clk);
                cyc++;
            end
            wvalid = 1'b0;
            chk("wr_beats", i, l + 1);
            chk("wr_done", done, 1);
            chk("wr_err", err, 0);
            chk("wr_wready_off", wready, 0);
            @(negedge clk);
            chk("wr_done_pulse", done, 0);
        end
    endtask

    task automatic read_burst(input int a, input int l, input int stall_beat, input logic exp_err);
        bit ok;
        int i = 0;
        int cyc = 0;
        int stalls = 0;
        bit prev_stall = 0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        send_cmd(1'b0, a, l, ok);
        if (ok) begin
            chk("rd_first_latency", rvalid, 0);
            while (i <= l && cyc < 300) begin
                if (prev_stall) begin
                    chk("stall_rvalid", rvalid, 1);
                    chk("stall_rdata", rdata, pd);
                    chk("stall_rlast", rlast, pl);
                end
                if (rvalid) begin
                    if (i == stall_beat && stalls < 3) begin
                        rready = 1'b0;
                        stalls++;
                    end else begin
                        rready = ($urandom_range(0, 3) != 0);
                    end
                    if (rready) begin
                        chk("rd_data", rdata, model[(a + i) % DEPTH]);
                        chk("rd_last", rlast, (i == l));
                        rd_got[i]  = rdata;
                        last_rdata = rdata;
                        i++;
                    end
                    prev_stall = !rready;
                    pd = rdata;
                    pl = rlast;
                end else begin
                    rready = 1'($urandom_range(0, 1));
                    prev_stall = 0;
                end
                @(negedge clk);
                cyc++;
            end
            rready = 1'b0;
            chk("rd_beats", i, l + 1);
            chk("rd_done", done, 1);
            chk("rd_err", err, exp_err);
            chk("rd_rvalid_off", rvalid, 0);
            @(negedge clk);
            chk("rd_done_pulse", done, 0);
        end
    endtask

    task automatic bad_cmd(input logic w, input int a);
        bit ok;
        bit seen = 0;
        send_cmd(w, a, $urandom_range(0, 15), ok);
        if (ok) begin
            wvalid = 1'b1;
            wdata  = $urandom;
            wstrb  = 4'hF;
            rready = 1'b1;
            for (int c = 0; c < 4 && !seen; c++) begin
                chk("bad_no_wready", wready, 0);
                chk("bad_no_rvalid", rvalid, 0);
                if (done) begin
                    seen = 1;
                    chk("bad_err", err, 1);
                end
                @(negedge clk);
            end
            wvalid = 1'b0;
            rready = 1'b0;
            chk("bad_done_seen", seen, 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        res = 1'b1;
        #1;
        chk("rel_ready_low", ready, 0);
        @(negedge clk);
        chk("rel_ready_high", ready, 1);

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 16; j++) begin
                bdata[j] = $urandom;
                bstrb[j] = 4'hF;
            end
            write_burst(16 * k, 15);
        end

        // partial strobe update
        bdata[0] = 32'hAABBCCDD; bstrb[0] = 4'hF;
        write_burst(5, 0);
        bdata[0] = 32'h00000011; bstrb[0] = 4'h1;
        write_burst(5, 0);
        read_burst(5, 0, -1, 1'b0);
        chk("t1_merge", last_rdata, 32'hAABBCC11);

        // burst wrapping past the top word
        for (int j = 0; j < 4; j++) begin
            bdata[j] = 32'(j + 1);
            bstrb[j] = 4'hF;
        end
        write_burst(DEPTH - 2, 3);
        read_burst(0, 1, -1, 1'b0);
        chk("t2_wrap0", rd_got[0], 32'd3);
        chk("t2_wrap1", rd_got[1], 32'd4);
        read_burst(DEPTH - 2, 1, -1, 1'b0);
        chk("t2_top0", rd_got[0], 32'd1);
        chk("t2_top1", rd_got[1], 32'd2);

        read_burst(10, 3, 1, 1'b0);

        bad_cmd(1'b1, 50);
        read_burst(50 % DEPTH, 0, -1, 1'b0);
        bad_cmd(1'b0, 63);

        // reset during the third beat of a four-beat write
        begin
            bit ok;
            for (int j = 0; j < 4; j++) begin
                bdata[j] = $urandom;
                bstrb[j] = 4'hF;
            end
            send_cmd(1'b1, 20, 3, ok);
            for (int j = 0; j < 2; j++) begin
                wvalid = 1'b1;
                wdata  = bdata[j];
                wstrb  = 4'hF;
                chk("t5_wready", wready, 1);
                model[20 + j] = bdata[j];
                @(negedge clk);
            end
            wdata = bdata[2];
            res = 1'b0;
            #1;
            chk("t5_ready", ready, 0);
            chk("t5_wready0", wready, 0);
            chk("t5_rvalid", rvalid, 0);
            chk("t5_rlast", rlast, 0);
            chk("t5_done", done, 0);
            chk("t5_err", err, 0);
            chk("t5_rdata", rdata, 0);
            @(negedge clk);
            @(negedge clk);
            wvalid = 1'b0;
            res = 1'b1;
            #1;
            chk("t5_ready_rel", ready, 0);
            @(negedge clk);
            chk("t5_ready_up", ready, 1);
            read_burst(20, 3, -1, 1'b0);
        end

        for (int n = 0; n < 40; n++) begin
            int a;
            int l;
            a = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) begin
                bad_cmd(1'($urandom), $urandom_range(DEPTH, 63));
            end else if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 16; j++) begin
                    bdata[j] = $urandom;
                    bstrb[j] = 4'($urandom);
                end
                write_burst(a, l);
            end else begin
                read_burst(a, l, $urandom_range(0, l), 1'b0);
            end
        end

        bdata[0] = 32'h12345678; bstrb[0] = 4'hF;
        write_burst(7, 0);
`ifdef PARITY_EN
        dut.mem_q[7] = dut.mem_q[7] ^ 32'h0000_0100;
        model[7] = model[7] ^ 32'h0000_0100;
        read_burst(7, 0, -1, 1'b1);
        chk("t6_flipped", last_rdata, 32'h12345778);
`else
        read_burst(7, 0, -1, 1'b0);
        chk("t6_plain", last_rdata, 32'h12345678);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
